div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/div_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-port divider arbiter.
package div_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam int DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; ptr names the requester that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between two requesters,
// one job in flight, with divide-by-zero bypass and timeout.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Req0_valid,
    input  logic        Req1_valid,
    output logic        Req0_ready,
    output logic        Req1_ready,
    input  logic [31:0] Req0_dividend,
    input  logic [31:0] Req1_dividend,
    input  logic [31:0] Req0_divisor,
    input  logic [31:0] Req1_divisor,
    output logic        Rsp0_valid,
    output logic        Rsp1_valid,
    input  logic        Rsp0_ready,
    input  logic        Rsp1_ready,
    output logic [31:0] Rsp0_quotient,
    output logic [31:0] Rsp1_quotient,
    output logic [31:0] Rsp0_remainder,
    output logic [31:0] Rsp1_remainder,
    output logic        Rsp0_div0,
    output logic        Rsp1_div0,
    output logic        Rsp0_err,
    output logic        Rsp1_err,
    output logic        Div_Run,
    output logic [31:0] Div_Dividend,
    output logic [31:0] Div_Divisor,
    input  logic        Div_Ready,
    input  logic [31:0] Div_Quotient,
    input  logic [31:0] Div_Remainder
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state;
    logic        ptr;
    logic        owner;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic        div_run;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_q;
    logic [31:0] rsp_r;
    logic        rsp_div0;
    logic        rsp_err;

    logic [1:0]  req_valid;
    logic [1:0]  grant;
    logic [1:0]  owner_oh;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    assign req_valid = {Req1_valid, Req0_valid};

    rr_arbiter2 u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign sel_a    = grant[1] ? Req1_dividend : Req0_dividend;
    assign sel_b    = grant[1] ? Req1_divisor  : Req0_divisor;
    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign cnt_inc  = cnt + 1'b1;

    // Readiness is purely combinational so a grant costs no extra cycle.
    assign Req0_ready = Reset && (state == IDLE) && grant[0];
    assign Req1_ready = Reset && (state == IDLE) && grant[1];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            div_run   <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_div0  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        owner <= grant[1];
                        ptr   <= ~grant[1];
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        if (sel_b == '0) begin
                            rsp_q     <= DIV0_QUOTIENT;
                            rsp_r     <= sel_a;
                            rsp_div0  <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_valid <= grant;
                            state     <= RESP;
                        end else begin
                            div_run <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_run <= 1'b0;
                    cnt     <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_div0  <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end else if (!Div_Ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    // A result on the last allowed cycle beats the timeout.
                    if (Div_Ready) begin
                        rsp_q     <= Div_Quotient;
                        rsp_r     <= Div_Remainder;
                        rsp_div0  <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end else if (cnt_inc == CW'(TIMEOUT)) begin
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_div0  <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if ((rsp_valid & {Rsp1_ready, Rsp0_ready}) != 2'b00) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Div_Run      = div_run;
    assign Div_Dividend = op_a;
    assign Div_Divisor  = op_b;

    assign Rsp0_valid     = rsp_valid[0];
    assign Rsp1_valid     = rsp_valid[1];
    assign Rsp0_quotient  = rsp_valid[0] ? rsp_q : '0;
    assign Rsp1_quotient  = rsp_valid[1] ? rsp_q : '0;
    assign Rsp0_remainder = rsp_valid[0] ? rsp_r : '0;
    assign Rsp1_remainder = rsp_valid[1] ? rsp_r : '0;
    assign Rsp0_div0      = rsp_valid[0] & rsp_div0;
    assign Rsp1_div0      = rsp_valid[1] & rsp_div0;
    assign Rsp0_err       = rsp_valid[0] & rsp_err;
    assign Rsp1_err       = rsp_valid[1] & rsp_err;

endmodule
